// File: rtl/logic_axi4_stream_upsizer_pkg.sv
// Shared constants and design-rule helpers for the AXI4-Stream width upsizer.
// Lane and counter widths stay local to the top because they depend on its parameters.
package logic_axi4_stream_upsizer_pkg;

    localparam int unsigned MIN_RATIO = 2;
    localparam int unsigned MIN_WIDTH = 1;

    function automatic bit ratio_ok(input int unsigned ratio);
        return ratio >= MIN_RATIO;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return width >= MIN_WIDTH;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_upsizer.sv
// AXI4-Stream upsizer: packs RATIO narrow beats into one wide word, with rx_tlast closing
// a partial word. The accumulator doubles as the output register.
module logic_axi4_stream_upsizer
    import logic_axi4_stream_upsizer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     rx_tvalid,
    input  logic [WIDTH-1:0]         rx_tdata,
    input  logic                     rx_tlast,
    output logic                     rx_tready,
    input  logic                     tx_tready,
    output logic                     tx_tvalid,
    output logic [WIDTH*RATIO-1:0]   tx_tdata,
    output logic [RATIO-1:0]         tx_tkeep,
    output logic                     tx_tlast
);

    localparam int LANE_W = WIDTH;
    localparam int CNT_W  = $clog2(RATIO);

    generate
        if (!ratio_ok(RATIO)) begin : g_drc_ratio
            $error("logic_axi4_stream_upsizer: RATIO must be >= 2");
        end
        if (!width_ok(WIDTH)) begin : g_drc_width
            $error("logic_axi4_stream_upsizer: WIDTH must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_n;
    logic                     valid_n;
    logic [WIDTH*RATIO-1:0]   data_n;
    logic [RATIO-1:0]         keep_n;
    logic                     last_n;
    logic                     accept;
    logic                     consume;
    logic                     word_done;

    assign rx_tready = areset_n && (!tx_tvalid || tx_tready);
    assign accept    = rx_tvalid && rx_tready;
    assign consume   = tx_tvalid && tx_tready;
    assign word_done = (cnt == CNT_W'(RATIO - 1)) || rx_tlast;

    // Consumption clears first so a beat accepted in the same cycle starts a fresh word.
    always_comb begin
        cnt_n   = cnt;
        valid_n = tx_tvalid;
        data_n  = tx_tdata;
        keep_n  = tx_tkeep;
        last_n  = tx_tlast;
        if (consume) begin
            valid_n = 1'b0;
            data_n  = '0;
            keep_n  = '0;
            last_n  = 1'b0;
        end
        if (accept) begin
            data_n[cnt*LANE_W +: LANE_W] = rx_tdata;
            keep_n[cnt]                  = 1'b1;
            if (word_done) begin
                valid_n = 1'b1;
                last_n  = rx_tlast;
                cnt_n   = '0;
            end else begin
                cnt_n   = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            cnt       <= '0;
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
            tx_tkeep  <= '0;
            tx_tlast  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            tx_tvalid <= valid_n;
            tx_tdata  <= data_n;
            tx_tkeep  <= keep_n;
            tx_tlast  <= last_n;
        end
    end

endmodule
